// File: rtl/cla_shift_add_multiplier.sv
// Sequential 16x16 unsigned shift-and-add multiplier built around one CLA_16_bit_LAC.
// Optional MUL_OVF_FLAG_EN registers ovf = |product[31:16]; otherwise ovf is tied to 0.
//
// state | meaning
// IDLE  | waiting for start; product/ovf hold last result
// RUN   | one add-and-shift per cycle, 16 cycles
// DONE  | done pulse, product valid; start here chains the next operation

module CLA_16_bit_LAC (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] sum,
  output logic        c_out,
  output logic        P,
  output logic        G
);
  logic [15:0] p, g, c;
  logic [3:0]  gp, gg, cg;

  always_comb begin
    p = a ^ b;
    g = a & b;
    for (int i = 0; i < 4; i++) begin
      gp[i] = &p[4*i +: 4];
      gg[i] = g[4*i+3] | (p[4*i+3] & g[4*i+2]) | (p[4*i+3] & p[4*i+2] & g[4*i+1])
            | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
    end
    // second-level lookahead across the four 4-bit groups
    cg[0] = c_in;
    cg[1] = gg[0] | (gp[0] & c_in);
    cg[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c_in);
    cg[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & c_in);
    G = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0]);
    P = &gp;
    c_out = G | (P & c_in);
    c = '0;
    for (int i = 0; i < 4; i++) begin
      c[4*i] = cg[i];
      for (int j = 1; j < 4; j++)
        c[4*i+j] = g[4*i+j-1] | (p[4*i+j-1] & c[4*i+j-1]);
    end
    sum = p ^ c;
  end
endmodule

module cla_shift_add_multiplier #(
  parameter int OP_W  = 16,
  parameter int CNT_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [OP_W-1:0]   multiplicand,
  input  logic [OP_W-1:0]   multiplier,
  output logic              busy,
  output logic              done,
  output logic [2*OP_W-1:0] product,
  output logic              ovf
);
  if (OP_W != 16) begin : g_bad_op_w
    $error("cla_shift_add_multiplier: OP_W must be 16 to match CLA_16_bit_LAC");
  end
  if ((1 << CNT_W) < OP_W) begin : g_bad_cnt_w
    $error("cla_shift_add_multiplier: CNT_W too narrow for OP_W iterations");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              state_q;
  logic [OP_W-1:0]     m_q, a_q, q_q;
  logic                c_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                busy_q, done_q;
  logic [2*OP_W-1:0]   product_q;
  logic [OP_W-1:0]     addend, sum;
  logic                c_out;
  logic [OP_W-1:0]     a_d, q_d;
  logic                last_iter;

  assign addend = q_q[0] ? m_q : '0;

  // c_q is cleared at every step, so the adder carry-in is always 0
  CLA_16_bit_LAC u_cla (
    .a     (a_q),
    .b     (addend),
    .c_in  (c_q),
    .sum   (sum),
    .c_out (c_out),
    .P     (),
    .G     ()
  );

  assign a_d       = {c_out, sum[OP_W-1:1]};
  assign q_d       = {sum[0], q_q[OP_W-1:1]};
  assign last_iter = (cnt_q == CNT_W'(OP_W - 1));

`ifdef MUL_OVF_FLAG_EN
  logic ovf_q;
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      m_q       <= '0;
      a_q       <= '0;
      q_q       <= '0;
      c_q       <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
`ifdef MUL_OVF_FLAG_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            m_q     <= multiplicand;
            q_q     <= multiplier;
            a_q     <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          a_q   <= a_d;
          q_q   <= q_d;
          c_q   <= 1'b0;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_iter) begin
            product_q <= {a_d, q_d};
`ifdef MUL_OVF_FLAG_EN
            ovf_q     <= |a_d;
`endif
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;
endmodule

// File: tb/tb_cla_shift_add_multiplier.sv
// Directed self-checking bench for cla_shift_add_multiplier: latency, handshake,
// edge-case operands, ignored mid-run start, reset abort and back-to-back chaining.
module tb_cla_shift_add_multiplier;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] mcand = '0;
  logic [15:0] mplier = '0;
  logic        busy, done, ovf;
  logic [31:0] product;

  int n_checks = 0;
  int n_pass   = 0;

  cla_shift_add_multiplier dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (mcand),
    .multiplier   (mplier),
    .busy         (busy),
    .done         (done),
    .product      (product),
    .ovf          (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic exp_ovf(input logic [31:0] p);
`ifdef MUL_OVF_FLAG_EN
    return |p[31:16];
`else
    return 1'b0;
`endif
  endfunction

  // counts posedges until done is seen (bounded)
  task automatic wait_done(output int cycles);
    cycles = 0;
    do begin
      @(posedge clk); #1;
      cycles++;
    end while (!done && cycles < 60);
  endtask

  // start accepted at the next posedge; returns just after that edge
  task automatic launch(input logic [15:0] m, input logic [15:0] q);
    @(negedge clk);
    start  = 1'b1;
    mcand  = m;
    mplier = q;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [15:0] m, input logic [15:0] q,
                        input logic [31:0] exp_p);
    int cyc;
    launch(m, q);
    check({tag, " busy_run"}, 32'(busy), 32'd1);
    wait_done(cyc);
    check({tag, " latency"}, 32'(cyc), 32'd16);
    check({tag, " product"}, product, exp_p);
    check({tag, " ovf"}, 32'(ovf), 32'(exp_ovf(exp_p)));
    check({tag, " busy_done"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    check({tag, " done_pulse"}, 32'(done), 32'd0);
    check({tag, " hold"}, product, exp_p);
  endtask

  initial begin
    int cyc;
    int seen_done;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst product", product, 32'h0);
    check("rst ovf", 32'(ovf), 32'd0);

    run_op("3x5", 16'h0003, 16'h0005, 32'h0000_000F);
    run_op("ffff_sq", 16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
    run_op("q_zero", 16'h1234, 16'h0000, 32'h0000_0000);
    run_op("m_zero", 16'h0000, 16'hABCD, 32'h0000_0000);
    run_op("ab_mix", 16'h1234, 16'h5678, 32'h0626_0060);

    // start re-asserted with new operands during RUN must be ignored
    launch(16'h0100, 16'h0100);
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1; mcand = 16'hFFFF; mplier = 16'hFFFF;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc);
    check("midrun latency", 32'(cyc), 32'd11);
    check("midrun product", product, 32'h0001_0000);
    check("midrun ovf", 32'(ovf), 32'(exp_ovf(32'h0001_0000)));

    // reset during RUN cycle 8 aborts with no done
    launch(16'h0003, 16'h0005);
    repeat (7) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort product", product, 32'h0);
    check("abort ovf", 32'(ovf), 32'd0);
    seen_done = 0;
    repeat (24) begin
      @(posedge clk); #1;
      if (done) seen_done++;
    end
    check("abort no_done", 32'(seen_done), 32'd0);

    // back-to-back: start held through DONE picks up the new operands
    @(negedge clk);
    start = 1'b1; mcand = 16'h0003; mplier = 16'h0005;
    @(posedge clk); #1;
    mcand = 16'h00FF; mplier = 16'h0002;
    wait_done(cyc);
    check("b2b first latency", 32'(cyc), 32'd16);
    check("b2b first product", product, 32'h0000_000F);
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b reaccept busy", 32'(busy), 32'd1);
    check("b2b reaccept done", 32'(done), 32'd0);
    wait_done(cyc);
    check("b2b second latency", 32'(cyc + 1), 32'd17);
    check("b2b second product", product, 32'h0000_01FE);
    check("b2b second ovf", 32'(ovf), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
